// File: rtl/modport_alu.sv
// RV32I integer ALU for the execute stage: decodes alu_op, registers result/zero
// with one cycle of latency and an in_valid/out_valid qualifier pair.
module modport_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  function automatic logic [WIDTH-1:0] alu_core(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic        [4:0]       shamt;
    logic        [WIDTH-1:0] res;
    sa    = a;
    sb    = b;
    shamt = b[4:0];
    res   = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SUB:  res = a - b;
      OP_SRA:  res = sa >>> shamt;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] w_result_p0;
  logic             w_zero_p0;
  logic [WIDTH-1:0] r_result_p1;
  logic             r_zero_p1;
  logic             r_vld_p1;

  assign w_result_p0 = alu_core(alu_op, in_a, in_b);
  assign w_zero_p0   = (w_result_p0 == '0);

  // p0 -> p1: capture on valid only so result/zero hold across idle cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_p1 <= '0;
      r_zero_p1   <= 1'b1;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_result_p1 <= w_result_p0;
        r_zero_p1   <= w_zero_p0;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign result    = r_result_p1;
  assign zero      = r_zero_p1;

endmodule

// File: tb/tb_modport_alu.sv
// Bench for modport_alu: table vectors, hand sequences and a random stream, all
// scored through a per-cycle expected-output queue.
module tb_modport_alu;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  alu_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;

  modport_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .result(result), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  typedef struct {
    string       name;
    logic        vld;
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] hold_res = 32'h0;
  logic        hold_z   = 1'b1;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0]  s;
    logic [31:0] fill;
    s = b[4:0];
    fill = a[31] ? ~(32'hffff_ffff >> s) : 32'h0;
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << s;
      OP_SRL:  return a >> s;
      OP_SUB:  return a + ~b + 32'd1;
      OP_SRA:  return (a >> s) | fill;
      OP_SLT:  return {31'b0, (a[31] != b[31]) ? a[31] : (a < b)};
      OP_SLTU: return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  // One cycle of stimulus; the expected registered outputs go to the scoreboard.
  task automatic step(input string name, input logic rst, input logic vld,
                      input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eres, input logic ez);
    exp_t e;
    @(negedge clk);
    reset = rst; in_valid = vld; alu_op = op; in_a = a; in_b = b;
    if (rst) begin
      hold_res = 32'h0; hold_z = 1'b1;
      e = '{name, 1'b0, 32'h0, 1'b1};
    end else if (vld) begin
      hold_res = eres; hold_z = ez;
      e = '{name, 1'b1, eres, ez};
    end else begin
      e = '{name, 1'b0, hold_res, hold_z};
    end
    sb_q.push_back(e);
  endtask

  task automatic step_model(input string name, input logic rst, input logic vld,
                            input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    m = model(op, a, b);
    step(name, rst, vld, op, a, b, m, (m == 32'h0));
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_total++;
      if (out_valid === e.vld) n_pass++;
      else $display("FAIL %s out_valid: got %b want %b", e.name, out_valid, e.vld);
      n_total++;
      if (result === e.res) n_pass++;
      else $display("FAIL %s result: got %h want %h", e.name, result, e.res);
      n_total++;
      if (zero === e.z) n_pass++;
      else $display("FAIL %s zero: got %b want %b", e.name, zero, e.z);
    end
  end

  vec_t tbl[$];

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_op = 4'h0; in_a = 32'h0; in_b = 32'h0;

    tbl.push_back('{"add_wrap",  OP_ADD,  32'hffffffff, 32'h00000001, 32'h00000000, 1'b1});
    tbl.push_back('{"sub_neg",   OP_SUB,  32'h00000003, 32'h00000005, 32'hfffffffe, 1'b0});
    tbl.push_back('{"sub_eq",    OP_SUB,  32'h1234abcd, 32'h1234abcd, 32'h00000000, 1'b1});
    tbl.push_back('{"and",       OP_AND,  32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0});
    tbl.push_back('{"or",        OP_OR,   32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 1'b0});
    tbl.push_back('{"xor",       OP_XOR,  32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 1'b0});
    tbl.push_back('{"sll_mask",  OP_SLL,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0});
    tbl.push_back('{"srl_31",    OP_SRL,  32'h80000000, 32'd31,       32'h00000001, 1'b0});
    tbl.push_back('{"sra_4",     OP_SRA,  32'h80000000, 32'd4,        32'hf8000000, 1'b0});
    tbl.push_back('{"sra_0",     OP_SRA,  32'h7fffffff, 32'd0,        32'h7fffffff, 1'b0});
    tbl.push_back('{"slt_neg",   OP_SLT,  32'hffffffff, 32'h00000001, 32'h00000001, 1'b0});
    tbl.push_back('{"sltu_big",  OP_SLTU, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1});
    tbl.push_back('{"slt_min",   OP_SLT,  32'h80000000, 32'h7fffffff, 32'h00000001, 1'b0});
    tbl.push_back('{"srl_0",     OP_SRL,  32'h89abcdef, 32'hffffffe0, 32'h89abcdef, 1'b0});
    tbl.push_back('{"rsv_1111",  4'b1111, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b1});

    // Reset held with a valid ADD pending, then released.
    step("rst_a", 1'b1, 1'b1, OP_ADD, 32'd5, 32'd7, 32'h0, 1'b1);
    step("rst_b", 1'b1, 1'b1, OP_ADD, 32'd5, 32'd7, 32'h0, 1'b1);
    step("add_12", 1'b0, 1'b1, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].name, 1'b0, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].z);

    // Back-to-back stream with a reserved op, an idle cycle, then mid-stream reset.
    step("str_add", 1'b0, 1'b1, OP_ADD, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0);
    step("str_sub", 1'b0, 1'b1, OP_SUB, 32'h00000100, 32'h00000001, 32'h000000ff, 1'b0);
    step("str_rsv", 1'b0, 1'b1, 4'b1100, 32'hdeadbeef, 32'h1, 32'h00000000, 1'b1);
    step("str_and", 1'b0, 1'b1, OP_AND, 32'hdeadbeef, 32'h0000ffff, 32'h0000beef, 1'b0);
    step("idle_hold", 1'b0, 1'b0, OP_ADD, 32'h1, 32'h1, 32'h0, 1'b0);
    step("str_or", 1'b0, 1'b1, OP_OR, 32'h00000a00, 32'h000000b0, 32'h00000ab0, 1'b0);
    step("mid_rst", 1'b1, 1'b1, OP_ADD, 32'h1, 32'h2, 32'h0, 1'b1);
    step("post_rst_idle", 1'b0, 1'b0, OP_ADD, 32'h1, 32'h2, 32'h0, 1'b1);
    step("post_rst_add", 1'b0, 1'b1, OP_ADD, 32'h1, 32'h2, 32'h00000003, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 5 == 0) ? a : $urandom;
      step_model("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), op, a, b);
    end

    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/modport_alu.md
Name: modport_alu

Overview:
- 32-bit RV32I integer ALU for the execute stage of the RISC-V core.
- Decodes a 4-bit alu_op and computes a 32-bit result and a zero flag from two operands.
- Outputs are registered: one-cycle latency, with an in_valid/out_valid qualifier pair.
- The combinational core is exposed on the same signal names as alu_intf (alu_op, in_a, in_b, result, zero).

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported. Shift amount is in_b[4:0].

Ports:
- clk       input   1   single clock; all state updates on rising edge
- reset     input   1   synchronous, active-high reset
- in_valid  input   1   operands/op valid this cycle
- alu_op    input   4   operation select
- in_a      input   32  operand A (rs1 / PC)
- in_b      input   32  operand B (rs2 / immediate)
- out_valid output  1   result/zero valid (in_valid delayed one cycle)
- result    output  32  registered operation result
- zero      output  1   registered flag, 1 iff the registered result == 0

Behaviour:
- Reset: on a rising clk edge with reset=1 → result=32'h0, zero=1, out_valid=0. Reset overrides in_valid in the same cycle. A mid-stream reset discards the pending result.
- Latency: operands sampled at edge N with in_valid=1 → result/zero/out_valid=1 visible after edge N.
- Edge with in_valid=0 → out_valid=0; result and zero hold their previous values.
- No backpressure; a new op is accepted every cycle (full throughput).
- alu_op encoding (all arithmetic modulo 2^32, no overflow/carry outputs):
  - 0000 AND: in_a & in_b
  - 0001 OR: in_a | in_b
  - 0010 ADD: in_a + in_b (wraps)
  - 0011 XOR: in_a ^ in_b
  - 0100 SLL: in_a << in_b[4:0]
  - 0101 SRL: logical right shift by in_b[4:0]
  - 0110 SUB: in_a - in_b (wraps)
  - 0111 SRA: arithmetic right shift by in_b[4:0], sign-filled from in_a[31]
  - 1000 SLT: signed compare; result = {31'b0, $signed(in_a) < $signed(in_b)}
  - 1001 SLTU: unsigned compare; result = {31'b0, in_a < in_b}
  - 1010–1111: reserved; result = 32'h0, zero = 1
- Shifts ignore in_b[31:5]. A shift amount of 0 returns in_a unchanged.
- zero is derived from the computed result in the same cycle. It is never independently stale relative to result.
- Unknown-free: with reset asserted at least one cycle, outputs are never X.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1, ADD 5+7 → result=0, zero=1, out_valid=0. Release reset → next cycle result=12, zero=0, out_valid=1.
- Arithmetic wrap and zero flag:
  - ADD ffffffff+00000001 → result=00000000, zero=1.
  - SUB 00000003-00000005 → fffffffe, zero=0.
  - SUB 1234abcd-1234abcd → 0, zero=1.
- Logic ops with a=f0f0f0f0, b=ff00ff00:
  - AND → f000f000
  - OR → fff0fff0
  - XOR → 0ff00ff0
- Shifts:
  - SLL 00000001 by b=00000023 (uses 3) → 00000008.
  - SRL 80000000 by 31 → 00000001.
  - SRA 80000000 by 4 → f8000000.
  - SRA 7fffffff by 0 → 7fffffff.
- Compares with a=ffffffff, b=00000001:
  - SLT → 00000001.
  - SLTU → 00000000, zero=1.
  - SLT a=80000000, b=7fffffff → 1.
- Streaming and reserved ops:
  - Back-to-back in_valid ADD, SUB, op 1100, AND on consecutive cycles → outputs appear one cycle later in order. Op 1100 gives 0 / zero=1.
  - Drop in_valid for one cycle → out_valid=0 and result holds its last value.
  - Reset asserted mid-stream clears outputs the next edge.
